// File: rtl/id_ex_stage.sv
// Decode->execute pipeline register with load-use hazard detection and event counters.
// Latency: 1 cycle id->ex; a load-use stall costs exactly one bubble.
// Backpressure: hold freezes the stage; stall_out stops PC/IF-ID on hold or load-use.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [2:0]       id_funct3,
  input  logic             id_funct7b5,
  input  logic [8:0]       id_ctrl,
  input  logic             hold,
  input  logic             flush,
  output logic             stall_out,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [2:0]       ex_funct3,
  output logic             ex_funct7b5,
  output logic [8:0]       ex_ctrl,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // ex_ctrl[7] is mem_read: the instruction in EX is a load.
  logic load_use;
  logic bubble;

  // Load-use detection: both source indices compared unconditionally (spurious stalls are harmless).
  always_comb begin
    load_use = id_valid & ex_valid & ex_ctrl[7] & (ex_rd != 5'd0) &
               ((ex_rd == id_rs1) | (ex_rd == id_rs2));
    bubble   = flush | load_use;
  end

  // Flush overrides the stall because the decode instruction is killed anyway; forced low in reset.
  assign stall_out = rst_n & (hold | (load_use & ~flush));

  // Pipeline register: hold freezes, flush/load-use inject a bubble, otherwise capture decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_funct3   <= '0;
      ex_funct7b5 <= 1'b0;
      ex_ctrl     <= '0;
    end else if (!hold) begin
      if (bubble) begin
        ex_valid    <= 1'b0;
        ex_pc       <= '0;
        ex_rs1_data <= '0;
        ex_rs2_data <= '0;
        ex_imm      <= '0;
        ex_rs1      <= '0;
        ex_rs2      <= '0;
        ex_rd       <= '0;
        ex_funct3   <= '0;
        ex_funct7b5 <= 1'b0;
        ex_ctrl     <= '0;
      end else begin
        ex_valid    <= id_valid;
        ex_pc       <= id_pc;
        ex_rs1_data <= id_rs1_data;
        ex_rs2_data <= id_rs2_data;
        ex_imm      <= id_imm;
        ex_rs1      <= id_rs1;
        ex_rs2      <= id_rs2;
        ex_rd       <= id_rd;
        ex_funct3   <= id_funct3;
        ex_funct7b5 <= id_funct7b5;
        // An invalid slot must never carry live control (e.g. reg_write) into EX.
        ex_ctrl     <= id_valid ? id_ctrl : 9'b0;
      end
    end
  end

  // Saturating bubble counters; flush takes priority so a simultaneous load-use is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!hold) begin
      if (flush) begin
        if (flush_cnt != {CNT_W{1'b1}}) flush_cnt <= flush_cnt + 1'b1;
      end else if (load_use) begin
        if (stall_cnt != {CNT_W{1'b1}}) stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule
